// File: rtl/ds_pkg.sv
// Shared types and helpers for the lib_ds stream blocks.
package ds_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } t_arb_state;

   // Ceiling log2, never less than 1 so a 1-entry index still has a bit.
   function automatic int sclog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << r) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int idx_w(input int n);
      return sclog2(n);
   endfunction

endpackage

// File: rtl/ds_if.sv
// Valid/ready stream bundle; xfer marks a completed beat.
interface ds_if #(
   parameter type DTYPE = logic [7:0]
) ();

   DTYPE data;
   logic vld;
   logic rdy;
   logic xfer;

   assign xfer = vld & rdy;

   modport mst (output data, output vld, input rdy, input xfer);
   modport slv (input data, input vld, input xfer, output rdy);

endinterface

// File: rtl/ds_arb_rr_pick.sv
// Combinational cyclic priority picker: first set bit of vld_i at or after start_i.
module ds_arb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  vld_i,
   input  logic [IW-1:0] start_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   logic [IW:0] pos;

   // Scanning from the far end lets the nearest hit overwrite the others.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, start_i} + (IW + 1)'(k);
         if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
         if (vld_i[pos[IW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/ds_arb.sv
// Round-robin arbiter sharing one ds_if sink among N_REQ requesters.
// Define DS_ARB_BURST_EN to hold a grant for up to BURST transfers.
module ds_arb
   import ds_pkg::*;
#(
   parameter type DTYPE = logic [7:0],
   parameter int  N_REQ = 4,
   parameter int  BURST = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   ds_if.slv                        if_req [N_REQ],
   ds_if.mst                        if_out,
   output logic                     o_gnt_vld,
   output logic [idx_w(N_REQ)-1:0]  o_gnt_idx
);

   localparam int IW = idx_w(N_REQ);

   logic [N_REQ-1:0] req_vld;
   logic [N_REQ-1:0] req_rdy;
   DTYPE             req_data [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_req
      assign req_vld[g]   = if_req[g].vld;
      assign req_data[g]  = if_req[g].data;
      assign if_req[g].rdy = req_rdy[g];
   end

   t_arb_state      q_state, d_state;
   logic [IW-1:0]   q_gnt, d_gnt;
   logic [IW-1:0]   q_last, d_last;
   logic [IW-1:0]   pick_start, pick_idx;
   logic            pick_found;
   logic            out_vld, out_xfer, rel, burst_end;

   assign pick_start = (q_last == IW'(N_REQ - 1)) ? '0 : q_last + IW'(1);

   ds_arb_rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .vld_i   (req_vld),
      .start_i (pick_start),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign out_xfer = (q_state == ARB_GRANT) & req_vld[q_gnt] & if_out.rdy;

`ifdef DS_ARB_BURST_EN
   localparam int CW = sclog2(BURST + 1);

   logic [CW-1:0] q_cnt, d_cnt;

   assign burst_end = (q_cnt == CW'(BURST - 1));

   always_comb begin
      d_cnt = '0;
      if (q_state == ARB_GRANT && !rel) begin
         d_cnt = out_xfer ? q_cnt + CW'(1) : q_cnt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) q_cnt <= '0;
      else          q_cnt <= d_cnt;
   end
`else
   localparam int unused_burst = BURST;

   // Every beat ends the grant when bursting is compiled out.
   assign burst_end = 1'b1;
`endif

   always_comb begin
      d_state = q_state;
      d_gnt   = q_gnt;
      d_last  = q_last;
      req_rdy = '0;
      out_vld = 1'b0;
      rel     = 1'b0;
      case (q_state)
         ARB_IDLE: begin
            if (pick_found) begin
               d_state = ARB_GRANT;
               d_gnt   = pick_idx;
               d_last  = pick_idx;
            end
         end
         ARB_GRANT: begin
            out_vld        = req_vld[q_gnt];
            req_rdy[q_gnt] = if_out.rdy;
            rel            = (out_xfer && burst_end) || !req_vld[q_gnt];
            // Re-pick in the release cycle so the next winner sees no bubble.
            if (rel) begin
               if (pick_found) begin
                  d_gnt  = pick_idx;
                  d_last = pick_idx;
               end else begin
                  d_state = ARB_IDLE;
               end
            end
         end
         default: d_state = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q_state <= ARB_IDLE;
         q_gnt   <= '0;
         q_last  <= IW'(N_REQ - 1);
      end else begin
         q_state <= d_state;
         q_gnt   <= d_gnt;
         q_last  <= d_last;
      end
   end

   assign if_out.vld  = out_vld;
   assign if_out.data = req_data[q_gnt];
   assign o_gnt_vld   = (q_state == ARB_GRANT);
   assign o_gnt_idx   = q_gnt;

endmodule

// File: tb/tb_ds_arb.sv
// Randomised and directed bench for ds_arb against a grant/burst reference model.
module tb_ds_arb;

   localparam int N        = 4;
   localparam int TB_BURST = 4;
`ifdef DS_ARB_BURST_EN
   localparam int BEFF = TB_BURST;
`else
   localparam int BEFF = 1;
`endif

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  vld;
   logic [7:0]    dat [N];
   logic          ordy;
   wire  [N-1:0]  rdy;
   wire           ovld;
   wire  [7:0]    odata;
   wire           ogv;
   wire  [1:0]    ogi;

   ds_if #(.DTYPE(logic [7:0])) req_if [N] ();
   ds_if #(.DTYPE(logic [7:0])) out_if ();

   for (genvar g = 0; g < N; g++) begin : g_req
      assign req_if[g].vld  = vld[g];
      assign req_if[g].data = dat[g];
      assign rdy[g]         = req_if[g].rdy;
   end

   assign out_if.rdy = ordy;
   assign ovld       = out_if.vld;
   assign odata      = out_if.data;

   ds_arb #(
      .DTYPE (logic [7:0]),
      .N_REQ (N),
      .BURST (TB_BURST)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .if_req    (req_if),
      .if_out    (out_if),
      .o_gnt_vld (ogv),
      .o_gnt_idx (ogi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: holder (-1 = none), last winner, beats left in burst.
   int         m_hold, m_last, m_left, m_gidx;
   int         xq_idx [$];
   logic [7:0] xq_dat [$];
   logic [15:0] act, exp16;

   assign act = {ovld, (ovld ? odata : 8'h00), rdy, ogv, ogi};

   function automatic int rr_next(input int after, input logic [N-1:0] v);
      for (int off = 1; off <= N; off++) begin
         int c;
         c = (after + off) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_hold = -1;
      m_last = N - 1;
      m_left = 0;
      m_gidx = 0;
      for (int i = 0; i < N; i++) dat[i] = 8'(i * 64);
   endtask

   task automatic model_expect();
      logic       e_ovld;
      logic [7:0] e_odata;
      logic [3:0] e_rdy;
      e_ovld  = 1'b0;
      e_odata = 8'h00;
      e_rdy   = '0;
      if (m_hold >= 0) begin
         e_ovld = vld[m_hold];
         if (e_ovld) e_odata = dat[m_hold];
         e_rdy[m_hold] = ordy;
      end
      exp16 = {e_ovld, e_odata, e_rdy, (m_hold >= 0), 2'(m_gidx)};
   endtask

   task automatic model_grant(input int p);
      m_hold = p;
      m_last = p;
      m_gidx = p;
      m_left = BEFF;
   endtask

   task automatic model_advance();
      int p, h;
      bit x;
      if (m_hold < 0) begin
         p = rr_next(m_last, vld);
         if (p >= 0) model_grant(p);
      end else begin
         h = m_hold;
         x = vld[h] && ordy;
         if (x) begin
            xq_idx.push_back(h);
            xq_dat.push_back(dat[h]);
            m_left--;
         end
         if (!vld[h] || (x && m_left == 0)) begin
            p = rr_next(m_last, vld);
            if (p >= 0) model_grant(p);
            else        m_hold = -1;
         end
         if (x) dat[h] = dat[h] + 8'd1;
      end
   endtask

   task automatic step(input logic [N-1:0] v, input logic r);
      vld  = v;
      ordy = r;
      @(negedge clk);
      model_expect();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      model_advance();
   endtask

   task automatic apply_reset();
      vld   = '0;
      ordy  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      xq_idx.delete();
      xq_dat.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      vld   = '1;
      ordy  = 1'b1;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      if (act !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h want=%h", act, 16'h0000);
      end
      n_chk++;
      vld = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      for (int c = 0; c < 3 * BEFF + 4; c++) begin
         step(4'b0100, 1'b1);
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL single c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         if (c == 1) begin
            if ({ogv, ogi} !== 3'b110) begin
               n_fail++;
               $display("FAIL single_latency got=%b want=%b", {ogv, ogi}, 3'b110);
            end
            n_chk++;
         end
         adv();
      end
   endtask

   task automatic test_all_rr();
      int cnt [N];
      int ei;
      apply_reset();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int c = 0; c < 8 * BEFF + 1; c++) begin
         step('1, 1'b1);
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL all_rr c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         adv();
      end
      if (xq_idx.size() !== 8 * BEFF) begin
         n_fail++;
         $display("FAIL all_rr_count got=%0d want=%0d", xq_idx.size(), 8 * BEFF);
      end
      n_chk++;
      for (int k = 0; k < xq_idx.size(); k++) begin
         ei = (k / BEFF) % N;
         if (xq_idx[k] !== ei || xq_dat[k] !== 8'(ei * 64 + cnt[ei])) begin
            n_fail++;
            $display("FAIL all_rr_order k%0d got=%0d/%h want=%0d/%h",
                     k, xq_idx[k], xq_dat[k], ei, 8'(ei * 64 + cnt[ei]));
         end
         n_chk++;
         cnt[ei]++;
      end
   endtask

   task automatic test_backpressure();
      logic r;
      apply_reset();
      for (int c = 0; c < 7 + 2 * BEFF; c++) begin
         r = !(c >= 2 && c < 7);
         step(4'b0010, r);
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL bp c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         if (!r && {ogv, ogi} !== 3'b101) begin
            n_fail++;
            $display("FAIL bp_hold c%0d got=%b want=%b", c, {ogv, ogi}, 3'b101);
         end
         if (!r) n_chk++;
         adv();
      end
      for (int k = 0; k < xq_dat.size(); k++) begin
         if (xq_dat[k] !== 8'(64 + k)) begin
            n_fail++;
            $display("FAIL bp_data k%0d got=%h want=%h", k, xq_dat[k], 8'(64 + k));
         end
         n_chk++;
      end
   endtask

   task automatic test_drop();
      logic [N-1:0] vs [5];
      logic         rs [5];
      vs = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0000};
      rs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         step(vs[c < 5 ? c : 4], rs[c < 5 ? c : 4]);
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL drop c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         if (c == 3 && {ogv, ogi} !== 3'b111) begin
            n_fail++;
            $display("FAIL drop_move got=%b want=%b", {ogv, ogi}, 3'b111);
         end
         if (c == 5 && ogv !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle got=%b want=0", ogv);
         end
         if (c == 3 || c == 5) n_chk++;
         adv();
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int c = 0; c < 2; c++) begin
         step(4'b0010, 1'b1);
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL arst_pre c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         adv();
      end
      #2 rst_n = 1'b0;
      #1;
      if ({ovld, rdy, ogv, ogi} !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_drop got=%h want=00", {ovld, rdy, ogv, ogi});
      end
      n_chk++;
      model_reset();
      vld = '1;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step('1, 1'b1);
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL arst_post c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         if (c == 1 && {ogv, ogi} !== 3'b100) begin
            n_fail++;
            $display("FAIL arst_first got=%b want=%b", {ogv, ogi}, 3'b100);
         end
         if (c == 1) n_chk++;
         adv();
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
         if (act !== exp16) begin
            n_fail++;
            $display("FAIL random c%0d got=%h want=%h", c, act, exp16);
         end
         n_chk++;
         adv();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      vld   = '0;
      ordy  = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_all_rr();
      test_backpressure();
      test_drop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
